// File: rtl/cache_arbiter_if.sv
// Bundles the I-cache, D-cache and physical-memory signals around the arbiter.
// slave: the arbiter's view. master: the caches and memory facing it.
interface cache_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic                  i_pmem_read;
    logic [ADDR_WIDTH-1:0] i_pmem_address;
    logic [LINE_WIDTH-1:0] i_pmem_rdata;
    logic                  i_pmem_resp;

    logic                  d_pmem_read;
    logic                  d_pmem_write;
    logic [ADDR_WIDTH-1:0] d_pmem_address;
    logic [LINE_WIDTH-1:0] d_pmem_wdata;
    logic [LINE_WIDTH-1:0] d_pmem_rdata;
    logic                  d_pmem_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Two-port (I/D) cache line arbiter in front of a single physical memory port.
// Round-robin between ports on contention; one memory transaction in flight.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; evaluate requests and grant/latch one port
// SERVE_I | I-port fill issued from latched fields, wait for pmem_resp
// SERVE_D | D-port fill/write-back issued from latched fields
// DONE    | one-cycle gap after completion, all commands/resps low
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic            clk,
    input  logic            reset,
    cache_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    state_t                state_q;
    state_t                state_d;
    port_t                 last_grant_q;
    port_t                 grant_port;
    logic                  grant_valid;
    logic                  i_req;
    logic                  d_req;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  op_write_q;

    logic                  cmd_read;
    logic                  cmd_write;
    logic                  i_resp;
    logic                  d_resp;

    assign i_req = bus.i_pmem_read;
    assign d_req = bus.d_pmem_read | bus.d_pmem_write;

    // On contention the port that did not win last time goes first.
    always_comb begin
        grant_port = PORT_I;
        if (i_req && d_req) begin
            if (last_grant_q == PORT_D) begin
                grant_port = PORT_I;
            end else begin
                grant_port = PORT_D;
            end
        end else if (d_req) begin
            grant_port = PORT_D;
        end
    end

    assign grant_valid = (state_q == IDLE) && (i_req || d_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_D;
        end else begin
            state_q <= state_d;
            if (grant_valid) begin
                last_grant_q <= grant_port;
            end
        end
    end

    // Request fields are captured once at grant; the memory sees only these copies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
        end else if (grant_valid) begin
            if (grant_port == PORT_D) begin
                addr_q     <= bus.d_pmem_address;
                wdata_q    <= bus.d_pmem_wdata;
                op_write_q <= bus.d_pmem_write;
            end else begin
                addr_q     <= bus.i_pmem_address;
                wdata_q    <= '0;
                op_write_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_read  = 1'b0;
        cmd_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_port == PORT_D) begin
                        state_d = SERVE_D;
                    end else begin
                        state_d = SERVE_I;
                    end
                end
            end
            SERVE_I: begin
                cmd_read  = ~op_write_q;
                cmd_write = op_write_q;
                if (bus.pmem_resp) begin
                    i_resp  = 1'b1;
                    state_d = DONE;
                end
            end
            SERVE_D: begin
                cmd_read  = ~op_write_q;
                cmd_write = op_write_q;
                if (bus.pmem_resp) begin
                    d_resp  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pmem_read    = cmd_read;
    assign bus.pmem_write   = cmd_write;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    assign bus.i_pmem_resp  = i_resp;
    assign bus.d_pmem_resp  = d_resp;

    // Return data fans out to both caches; each qualifies it with its own resp.
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: transaction-level model checked every cycle,
// plus literal expectations for the lone read, contention, latching and reset cases.
module tb_cache_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;
    localparam logic [LW-1:0] JUNK = 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_vec(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    int   mem_lat = 2;
    int   mem_cnt = 0;
    logic spur    = 1'b0;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {8{a}};
    endfunction

    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = JUNK;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_cnt        = 0;
                bus.pmem_resp  = spur;
                bus.pmem_rdata = JUNK;
            end else if (bus.pmem_read || bus.pmem_write) begin
                mem_cnt++;
                if (mem_cnt == mem_lat) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = line_of(bus.pmem_address);
                end else begin
                    bus.pmem_resp  = spur;
                    bus.pmem_rdata = JUNK;
                end
            end else begin
                mem_cnt        = 0;
                bus.pmem_resp  = spur;
                bus.pmem_rdata = JUNK;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic          m_busy, m_cool, m_owner_d, m_last_d, m_write;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic          ireq, dreq, prev_cmd, cmd_now;

    int            cmd_cyc[$];
    logic [AW-1:0] cmd_addr[$];
    logic          cmd_wr[$];
    logic [LW-1:0] cmd_wdata[$];
    int            iresp_cyc[$];
    logic [LW-1:0] iresp_data[$];
    int            dresp_cyc[$];

    initial begin
        m_busy = 0; m_cool = 0; m_owner_d = 0; m_last_d = 1; m_write = 0;
        m_addr = '0; m_wdata = '0; prev_cmd = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_busy = 0; m_cool = 0; m_owner_d = 0; m_last_d = 1; m_write = 0;
                m_addr = '0; m_wdata = '0;
            end
            chk_bit("pmem_read", bus.pmem_read, m_busy && !m_write);
            chk_bit("pmem_write", bus.pmem_write, m_busy && m_write);
            chk_vec("pmem_address", LW'(bus.pmem_address), LW'(m_addr));
            chk_vec("pmem_wdata", bus.pmem_wdata, m_wdata);
            chk_bit("i_pmem_resp", bus.i_pmem_resp, m_busy && !m_owner_d && bus.pmem_resp);
            chk_bit("d_pmem_resp", bus.d_pmem_resp, m_busy && m_owner_d && bus.pmem_resp);
            chk_vec("i_pmem_rdata", bus.i_pmem_rdata, bus.pmem_rdata);
            chk_vec("d_pmem_rdata", bus.d_pmem_rdata, bus.pmem_rdata);

            cmd_now = bus.pmem_read || bus.pmem_write;
            if (cmd_now && !prev_cmd) begin
                cmd_cyc.push_back(cyc);
                cmd_addr.push_back(bus.pmem_address);
                cmd_wr.push_back(bus.pmem_write);
                cmd_wdata.push_back(bus.pmem_wdata);
            end
            prev_cmd = cmd_now;
            if (bus.i_pmem_resp) begin
                iresp_cyc.push_back(cyc);
                iresp_data.push_back(bus.i_pmem_rdata);
            end
            if (bus.d_pmem_resp) dresp_cyc.push_back(cyc);

            // Advance: a transaction ends on resp, then one quiet cycle, then arbitrate.
            if (!reset) begin
                if (m_busy) begin
                    if (bus.pmem_resp) begin
                        m_busy = 0;
                        m_cool = 1;
                    end
                end else if (m_cool) begin
                    m_cool = 0;
                end else begin
                    ireq = bus.i_pmem_read;
                    dreq = bus.d_pmem_read || bus.d_pmem_write;
                    if (ireq || dreq) begin
                        m_owner_d = (ireq && dreq) ? !m_last_d : dreq;
                        m_last_d  = m_owner_d;
                        m_busy    = 1;
                        if (m_owner_d) begin
                            m_addr  = bus.d_pmem_address;
                            m_wdata = bus.d_pmem_wdata;
                            m_write = bus.d_pmem_write;
                        end else begin
                            m_addr  = bus.i_pmem_address;
                            m_wdata = '0;
                            m_write = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        cmd_cyc.delete(); cmd_addr.delete(); cmd_wr.delete(); cmd_wdata.delete();
        iresp_cyc.delete(); iresp_data.delete(); dresp_cyc.delete();
    endtask

    task automatic clear_inputs();
        bus.i_pmem_read = 0; bus.i_pmem_address = '0;
        bus.d_pmem_read = 0; bus.d_pmem_write = 0;
        bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        tick(2);
        reset = 0;
        tick(1);
    endtask

    task automatic wait_resp(input logic port_d, input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if ((port_d ? bus.d_pmem_resp : bus.i_pmem_resp) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++; bad++;
            $display("FAIL %s_resp_timeout: got none want a resp within %0d cycles",
                     port_d ? "d" : "i", limit);
        end
    endtask

    task automatic wait_cmds(input int count, input int limit);
        int k;
        k = 0;
        while (cmd_cyc.size() < count && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (cmd_cyc.size() < count) begin
            total++; bad++;
            $display("FAIL cmd_timeout: got %0d commands want %0d", cmd_cyc.size(), count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    int n, ai, ad;
    logic [AW-1:0] exp_alt [4];

    initial begin
        clear_inputs();
        reset = 0;
        #1 reset = 1;
        #2;
        chk_bit("rst_pmem_read", bus.pmem_read, 1'b0);
        chk_bit("rst_pmem_write", bus.pmem_write, 1'b0);
        chk_vec("rst_pmem_address", LW'(bus.pmem_address), '0);
        chk_vec("rst_pmem_wdata", bus.pmem_wdata, '0);
        chk_bit("rst_i_resp", bus.i_pmem_resp, 1'b0);
        chk_bit("rst_d_resp", bus.d_pmem_resp, 1'b0);
        tick(2);
        reset = 0;
        tick(1);

        // Lone I-read, memory answers in the third command cycle.
        clear_logs();
        mem_lat = 3;
        n = cyc;
        bus.i_pmem_address = 16'h1230;
        bus.i_pmem_read = 1;
        wait_resp(1'b0, 20, ai);
        tick();
        bus.i_pmem_read = 0;
        tick(3);
        chk_int("s1_ncmd", cmd_cyc.size(), 1);
        if (cmd_cyc.size() > 0) begin
            chk_int("s1_cmd_cycle", cmd_cyc[0], n + 1);
            chk_vec("s1_cmd_addr", LW'(cmd_addr[0]), LW'(16'h1230));
            chk_bit("s1_cmd_is_read", cmd_wr[0], 1'b0);
        end
        chk_int("s1_iresp_cycle", ai, n + 3);
        chk_int("s1_niresp", iresp_data.size(), 1);
        if (iresp_data.size() > 0)
            chk_vec("s1_iresp_data", iresp_data[0], 128'h1230_1230_1230_1230_1230_1230_1230_1230);
        chk_int("s1_ndresp", dresp_cyc.size(), 0);

        // Simultaneous I-read / D-write straight after reset: I first.
        do_reset();
        clear_logs();
        mem_lat = 2;
        n = cyc;
        bus.i_pmem_address = 16'h0040; bus.i_pmem_read = 1;
        bus.d_pmem_address = 16'h0080; bus.d_pmem_wdata = {8{16'hC0DE}}; bus.d_pmem_write = 1;
        wait_resp(1'b0, 20, ai);
        tick();
        bus.i_pmem_read = 0;
        wait_resp(1'b1, 20, ad);
        tick();
        bus.d_pmem_write = 0;
        tick(2);
        chk_int("s2_ncmd", cmd_cyc.size(), 2);
        chk_int("s2_iresp_cycle", ai, n + 2);
        chk_int("s2_dresp_cycle", ad, n + 6);
        if (cmd_cyc.size() > 1) begin
            chk_vec("s2_first_addr", LW'(cmd_addr[0]), LW'(16'h0040));
            chk_bit("s2_first_read", cmd_wr[0], 1'b0);
            chk_int("s2_write_start", cmd_cyc[1], ai + 3);
            chk_vec("s2_second_addr", LW'(cmd_addr[1]), LW'(16'h0080));
            chk_bit("s2_second_write", cmd_wr[1], 1'b1);
            chk_vec("s2_second_wdata", cmd_wdata[1], {8{16'hC0DE}});
        end

        // Both ports held high: grants alternate I, D, I, D.
        clear_logs();
        mem_lat = 1;
        n = cyc;
        bus.i_pmem_address = 16'h0100; bus.i_pmem_read = 1;
        bus.d_pmem_address = 16'h0200; bus.d_pmem_read = 1;
        wait_cmds(4, 40);
        tick();
        bus.i_pmem_read = 0;
        bus.d_pmem_read = 0;
        tick(4);
        exp_alt[0] = 16'h0100; exp_alt[1] = 16'h0200;
        exp_alt[2] = 16'h0100; exp_alt[3] = 16'h0200;
        chk_int("s3_ncmd", cmd_cyc.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < cmd_cyc.size())
                chk_vec($sformatf("s3_grant%0d_addr", k), LW'(cmd_addr[k]), LW'(exp_alt[k]));
        end
        if (cmd_cyc.size() > 3) chk_int("s3_fourth_start", cmd_cyc[3], n + 10);
        chk_int("s3_niresp", iresp_cyc.size(), 2);
        chk_int("s3_ndresp", dresp_cyc.size(), 2);

        // D request with read+write (treated as write); inputs change after grant.
        clear_logs();
        mem_lat = 4;
        n = cyc;
        bus.d_pmem_address = 16'h2000; bus.d_pmem_wdata = {8{16'hAAAA}};
        bus.d_pmem_read = 1; bus.d_pmem_write = 1;
        tick();
        bus.d_pmem_address = 16'h3000; bus.d_pmem_wdata = {8{16'h5555}};
        wait_resp(1'b1, 20, ad);
        tick();
        bus.d_pmem_read = 0; bus.d_pmem_write = 0;
        tick(2);
        chk_int("s4_dresp_cycle", ad, n + 4);
        chk_int("s4_ncmd", cmd_cyc.size(), 1);
        if (cmd_cyc.size() > 0) begin
            chk_bit("s4_is_write", cmd_wr[0], 1'b1);
            chk_vec("s4_addr", LW'(cmd_addr[0]), LW'(16'h2000));
            chk_vec("s4_wdata", cmd_wdata[0], {8{16'hAAAA}});
        end

        // Reset pulsed mid SERVE_D abandons the transaction.
        clear_logs();
        mem_lat = 10;
        bus.d_pmem_address = 16'h5000; bus.d_pmem_wdata = {8{16'h5A5A}}; bus.d_pmem_read = 1;
        wait_cmds(1, 10);
        #2 reset = 1;
        #1;
        chk_bit("s5_rst_read", bus.pmem_read, 1'b0);
        chk_bit("s5_rst_write", bus.pmem_write, 1'b0);
        chk_vec("s5_rst_addr", LW'(bus.pmem_address), '0);
        chk_vec("s5_rst_wdata", bus.pmem_wdata, '0);
        chk_bit("s5_rst_dresp", bus.d_pmem_resp, 1'b0);
        bus.d_pmem_read = 0;
        tick(2);
        reset = 0;
        tick(2);
        chk_int("s5_ndresp", dresp_cyc.size(), 0);
        clear_logs();
        mem_lat = 2;
        n = cyc;
        bus.i_pmem_address = 16'h6000; bus.i_pmem_read = 1;
        wait_resp(1'b0, 20, ai);
        tick();
        bus.i_pmem_read = 0;
        tick(2);
        chk_int("s5_fresh_resp_cycle", ai, n + 2);
        if (iresp_data.size() > 0)
            chk_vec("s5_fresh_data", iresp_data[0], 128'h6000_6000_6000_6000_6000_6000_6000_6000);

        // Spurious pmem_resp while idle is ignored.
        clear_logs();
        @(negedge clk); #2 spur = 1;
        @(negedge clk); #2 spur = 0;
        tick(3);
        chk_int("s6_niresp", iresp_cyc.size(), 0);
        chk_int("s6_ndresp", dresp_cyc.size(), 0);
        chk_int("s6_ncmd", cmd_cyc.size(), 0);
        mem_lat = 1;
        n = cyc;
        bus.i_pmem_address = 16'h7000; bus.i_pmem_read = 1;
        wait_resp(1'b0, 20, ai);
        tick();
        bus.i_pmem_read = 0;
        tick(2);
        if (cmd_cyc.size() > 0) chk_int("s6_after_latency", cmd_cyc[0], n + 1);
        chk_int("s6_after_resp", ai, n + 1);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
